// File: rtl/bsg_gateway_power_pkg.sv
// bsg_gateway_power_pkg: shared state encoding and override key decode for the power sequencer.
// Revision: 1.0
`default_nettype none

package bsg_gateway_power_pkg;

  typedef enum logic [2:0] {
    OFF       = 3'd0,
    RAMP_UP   = 3'd1,
    ON        = 3'd2,
    RAMP_DOWN = 3'd3,
    OVERRIDE  = 3'd4,
    FAULT     = 3'd5
  } power_state_e;

  // Only the exact (armed, not-disarmed) key pair unlocks the CPU override.
  function automatic logic override_active(input logic key_p, input logic key_n);
    return key_p & ~key_n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_gateway_power_step_timer.sv
// bsg_gateway_power_step_timer: loadable down-counter, done on the last cycle of a step.
// Revision: 1.0
`default_nettype none

module bsg_gateway_power_step_timer #(
  parameter int delay_width_p = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     load_i,
  input  logic [delay_width_p-1:0] value_i,
  output logic                     done_o
);

  localparam logic [delay_width_p-1:0] c_one = delay_width_p'(1);

  logic [delay_width_p-1:0] r_count;

  // A zero delay is clamped to one so a step never stalls or wraps.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= (value_i == '0) ? c_one : value_i;
    end else if (r_count != '0) begin
      r_count <= r_count - c_one;
    end
  end

  assign done_o = (r_count == c_one);

endmodule

`default_nettype wire

// File: rtl/bsg_gateway_power_seq.sv
// bsg_gateway_power_seq: ordered rail ramp-up/down with CPU override and latched fault shutdown.
// Revision: 1.0
`default_nettype none

module bsg_gateway_power_seq #(
  parameter int num_rails_p   = 3,
  parameter int delay_width_p = 24
) (
  input  logic                     clk_i,
  input  logic                     reset_n_i,
  input  logic                     power_up_req_i,
  input  logic                     power_down_req_i,
  input  logic [delay_width_p-1:0] step_delay_i,
  input  logic                     override_p_i,
  input  logic                     override_n_i,
  input  logic [num_rails_p-1:0]   override_en_i,
  input  logic                     fault_i,
  input  logic                     fault_clear_i,
  output logic [num_rails_p-1:0]   rail_en_o,
  output logic                     power_good_o,
  output logic                     busy_o,
  output logic                     fault_o,
  output logic [2:0]               state_o
);

  import bsg_gateway_power_pkg::*;

  localparam int                 c_idx_w    = (num_rails_p > 1) ? $clog2(num_rails_p) : 1;
  localparam logic [c_idx_w-1:0] c_last_idx = c_idx_w'(num_rails_p - 1);
  localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);

  power_state_e             r_state;
  power_state_e             w_state_next;
  logic [c_idx_w-1:0]       r_idx;
  logic [c_idx_w-1:0]       w_idx_next;
  logic [num_rails_p-1:0]   w_rail_next;
  logic                     w_load;
  logic                     w_step_done;
  logic                     w_override;

  assign w_override = override_active(override_p_i, override_n_i);

  bsg_gateway_power_step_timer #(
    .delay_width_p(delay_width_p)
  ) u_step_timer (
    .clk_i    (clk_i),
    .reset_n_i(reset_n_i),
    .load_i   (w_load),
    .value_i  (step_delay_i),
    .done_o   (w_step_done)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_rail_next  = rail_en_o;
    w_load       = 1'b0;

    if (fault_i) begin
      w_state_next = FAULT;
      w_idx_next   = '0;
      w_rail_next  = '0;
    end else if (r_state == FAULT) begin
      // Rails stay dark until software explicitly acknowledges a quiet monitor.
      w_rail_next = '0;
      if (fault_clear_i) begin
        w_state_next = OFF;
      end
    end else if (w_override) begin
      w_state_next = OVERRIDE;
      w_idx_next   = '0;
      w_rail_next  = override_en_i;
    end else begin
      case (r_state)
        OFF: begin
          w_idx_next  = '0;
          w_rail_next = '0;
          if (power_up_req_i && !power_down_req_i) begin
            w_state_next   = RAMP_UP;
            w_rail_next[0] = 1'b1;
            w_load         = 1'b1;
          end
        end

        RAMP_UP: begin
          if (power_down_req_i) begin
            // Abort: unwind from the highest rail already enabled.
            w_state_next       = RAMP_DOWN;
            w_rail_next[r_idx] = 1'b0;
            w_load             = 1'b1;
          end else if (w_step_done) begin
            if (r_idx == c_last_idx) begin
              w_state_next = ON;
            end else begin
              w_idx_next              = r_idx + c_idx_one;
              w_rail_next[w_idx_next] = 1'b1;
              w_load                  = 1'b1;
            end
          end
        end

        ON: begin
          if (power_down_req_i) begin
            w_state_next            = RAMP_DOWN;
            w_idx_next              = c_last_idx;
            w_rail_next[c_last_idx] = 1'b0;
            w_load                  = 1'b1;
          end
        end

        RAMP_DOWN: begin
          if (w_step_done) begin
            if (r_idx == '0) begin
              w_state_next = OFF;
            end else begin
              w_idx_next              = r_idx - c_idx_one;
              w_rail_next[w_idx_next] = 1'b0;
              w_load                  = 1'b1;
            end
          end
        end

        default: begin
          // Override released (or an illegal encoding): drop everything.
          w_state_next = OFF;
          w_idx_next   = '0;
          w_rail_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state      <= OFF;
      r_idx        <= '0;
      rail_en_o    <= '0;
      power_good_o <= 1'b0;
      busy_o       <= 1'b0;
      fault_o      <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_idx        <= w_idx_next;
      rail_en_o    <= w_rail_next;
      power_good_o <= (w_state_next == ON);
      busy_o       <= (w_state_next == RAMP_UP) || (w_state_next == RAMP_DOWN);
      fault_o      <= (w_state_next == FAULT);
    end
  end

  assign state_o = r_state;

endmodule

`default_nettype wire
